// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the fetch stage and its IF/ID register.
package rv_pipe_pkg;

  // Width of the PC fields carried in the IF/ID payload.
  localparam int XLEN_W = 32;

  // Bubble encoding: addi x0,x0,0.
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  // PC loaded when rst is asserted.
  localparam logic [XLEN_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]       instr;
    logic [XLEN_W-1:0] pc;
    logic [XLEN_W-1:0] pc_plus4;
    logic              valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic [31:0]     rdata;
  logic            ready;

  // The fetch stage issues requests; the memory answers them.
  modport master (output req, output addr, input rdata, input ready);
  modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush beats stall beats load; when nothing is
// loaded the register degrades to a bubble that keeps the last PC fields.
module if_id_reg
  import rv_pipe_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // Update the IF/ID payload; bubbles only touch instr/valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q.instr    <= NOP_INSTR;
      q.pc       <= '0;
      q.pc_plus4 <= '0;
      q.valid    <= 1'b0;
    end else if (flush) begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (stall) begin
      q <= q;
    end else if (load) begin
      q <= d;
    end else begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake, handles
// redirects/stalls/flushes and feeds decode through the IF/ID register.
// XLEN must match rv_pipe_pkg::XLEN_W since the IF/ID payload uses it.
module fetch_stage
  import rv_pipe_pkg::*;
#(
  parameter int              XLEN      = XLEN_W,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stall_F,
  input  logic            flush_D,
  input  logic            pc_src_E,
  input  logic [XLEN-1:0] pc_target_E,
  fetch_stage_if.master   imem,
  output logic [31:0]     instr_D,
  output logic [XLEN-1:0] pc_D,
  output logic [XLEN-1:0] pc_plus4_D,
  output logic            valid_D,
  output logic            busy
);

  fetch_state_t    state_reg;
  logic [XLEN-1:0] pc_reg;
  logic            req_reg;
  logic [31:0]     skid_instr_reg;
  logic [XLEN-1:0] skid_pc_reg;
  logic            pend_reg;
  logic [XLEN-1:0] pend_target_reg;

  logic [XLEN-1:0] target_aligned;
  logic [XLEN-1:0] pc_plus4;
  logic            in_fetch;
  logic            in_hold;
  logic            accept;
  logic            hold_release;
  logic            idd_load;
  logic            idd_flush;
  if_id_t          idd_d;
  if_id_t          idd_q;

  assign target_aligned = {pc_target_E[XLEN-1:2], 2'b00};
  assign pc_plus4       = pc_reg + XLEN'(4);
  assign in_fetch       = (state_reg == FETCH);
  assign in_hold        = (state_reg == HOLD);

  // A response is only consumed when nothing else claims this cycle.
  assign accept       = in_fetch && imem.ready && !stall_F && !flush_D &&
                        !pc_src_E && !pend_reg;
  assign hold_release = in_hold && !stall_F && !flush_D && !pc_src_E;
  assign idd_load     = accept || hold_release;
  assign idd_flush    = flush_D || pc_src_E;

  // Select the IF/ID source: skid buffer when leaving HOLD, else the bus.
  always_comb begin
    idd_d.valid = 1'b1;
    if (in_hold) begin
      idd_d.instr    = skid_instr_reg;
      idd_d.pc       = skid_pc_reg;
      idd_d.pc_plus4 = skid_pc_reg + XLEN'(4);
    end else begin
      idd_d.instr    = imem.rdata;
      idd_d.pc       = pc_reg;
      idd_d.pc_plus4 = pc_plus4;
    end
  end

  // Fetch FSM with PC, skid buffer, pending redirect and registered req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      req_reg         <= 1'b0;
      skid_instr_reg  <= '0;
      skid_pc_reg     <= '0;
      pend_reg        <= 1'b0;
      pend_target_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pc_src_E) pc_reg <= target_aligned;
          if (start) begin
            state_reg <= FETCH;
            req_reg   <= 1'b1;
          end
        end
        FETCH: begin
          if (pc_src_E) begin
            // The in-flight response (now or later) is thrown away.
            if (imem.ready) begin
              pc_reg   <= target_aligned;
              pend_reg <= 1'b0;
            end else begin
              pend_reg        <= 1'b1;
              pend_target_reg <= target_aligned;
            end
          end else if (pend_reg) begin
            if (imem.ready) begin
              pc_reg   <= pend_target_reg;
              pend_reg <= 1'b0;
            end
          end else if (imem.ready && !flush_D) begin
            if (stall_F) begin
              skid_instr_reg <= imem.rdata;
              skid_pc_reg    <= pc_reg;
              state_reg      <= HOLD;
              req_reg        <= 1'b0;
            end else begin
              pc_reg <= pc_plus4;
            end
          end
        end
        HOLD: begin
          if (pc_src_E) begin
            pc_reg    <= target_aligned;
            state_reg <= FETCH;
            req_reg   <= 1'b1;
          end else if (!stall_F) begin
            // A flush here drops the buffered word so it is fetched again.
            if (!flush_D) pc_reg <= pc_plus4;
            state_reg <= FETCH;
            req_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .load  (idd_load),
    .stall (stall_F),
    .flush (idd_flush),
    .d     (idd_d),
    .q     (idd_q)
  );

  assign imem.req   = req_reg;
  assign imem.addr  = pc_reg;
  assign instr_D    = idd_q.instr;
  assign pc_D       = idd_q.pc;
  assign pc_plus4_D = idd_q.pc_plus4;
  assign valid_D    = idd_q.valid;
  assign busy       = (state_reg != IDLE);

endmodule
